// File: rtl/codestream_readback_pkg.sv
// Shared definitions for the tier-2 codestream readback path.
package codestream_readback_pkg;

    localparam int unsigned CS_ADDR_W = 10;

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN,
        DONE
    } cs_state_t;

endpackage

// File: rtl/cs_buf_ram.sv
// Simple dual-port codestream buffer: byte-enabled write port, registered read port.
module cs_buf_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_dwt,
    input  logic [3:0]        wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_q
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk_dwt) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/codestream_readback.sv
// Captures one tier-2 codestream image into a local buffer, then streams it
// back to the host over a valid/ready interface through a 2-entry skid buffer.
module codestream_readback
    import codestream_readback_pkg::*;
#(
    parameter int unsigned ADDR_W = CS_ADDR_W
) (
    input  logic            clk_dwt,
    input  logic            rst,
    input  logic [3:0]      write_en,
    input  logic [31:0]     output_address,
    input  logic [31:0]     output_to_fpga_32,
    input  logic            one_image_over,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [31:0]     rd_data,
    output logic            rd_last,
    output logic [ADDR_W:0] image_words,
    output logic            overflow,
    output logic            wr_while_busy,
    output logic            readback_done
);

    cs_state_t       state;
    logic            oio_q;
    logic [ADDR_W:0] rd_addr;
    logic            inflight_q;
    logic            inflight_last_q;
    logic [31:0]     ram_q;
    logic [1:0]      sk_cnt;
    logic [31:0]     sk1_data;
    logic            sk1_last;

    logic            in_range;
    logic            cap_wr;
    logic            any_wr;
    logic            oio_rise;
    logic            pop;
    logic            push;
    logic            issue;
    logic            issue_last;
    logic [ADDR_W:0] wr_words;
    logic [ADDR_W:0] words_next;

    assign any_wr     = (write_en != '0);
    assign in_range   = ((output_address >> ADDR_W) == '0);
    assign cap_wr     = (state == CAPTURE) && any_wr && in_range;
    assign wr_words   = {1'b0, output_address[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
    assign words_next = (cap_wr && (wr_words > image_words)) ? wr_words : image_words;
    assign oio_rise   = one_image_over && !oio_q;
    assign pop        = rd_valid && rd_ready;
    assign push       = inflight_q;
    // A read may be issued only if the skid buffer can still absorb it once
    // it lands, counting the word already in flight and any pop this cycle.
    assign issue      = (state == DRAIN) && (rd_addr < image_words) &&
                        (({1'b0, sk_cnt} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));
    assign issue_last = (rd_addr == (image_words - {{ADDR_W{1'b0}}, 1'b1}));

    cs_buf_ram #(
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk_dwt (clk_dwt),
        .wr_en   (cap_wr ? write_en : 4'b0000),
        .wr_addr (output_address[ADDR_W-1:0]),
        .wr_data (output_to_fpga_32),
        .rd_en   (issue),
        .rd_addr (rd_addr[ADDR_W-1:0]),
        .rd_q    (ram_q)
    );

    always_ff @(posedge clk_dwt) begin
        if (rst) begin
            state           <= CAPTURE;
            oio_q           <= 1'b0;
            rd_addr         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            sk_cnt          <= '0;
            sk1_data        <= '0;
            sk1_last        <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            rd_last         <= 1'b0;
            image_words     <= '0;
            overflow        <= 1'b0;
            wr_while_busy   <= 1'b0;
            readback_done   <= 1'b0;
        end else begin
            oio_q         <= one_image_over;
            readback_done <= 1'b0;
            inflight_q    <= issue;
            if (issue) begin
                inflight_last_q <= issue_last;
                rd_addr         <= rd_addr + {{ADDR_W{1'b0}}, 1'b1};
            end

            // rd_* is the head entry; sk1_* holds the second word while stalled.
            unique case ({push, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0) begin
                        rd_data <= ram_q;
                        rd_last <= inflight_last_q;
                    end else begin
                        sk1_data <= ram_q;
                        sk1_last <= inflight_last_q;
                    end
                    sk_cnt   <= sk_cnt + 2'd1;
                    rd_valid <= 1'b1;
                end
                2'b01: begin
                    rd_data  <= sk1_data;
                    rd_last  <= sk1_last && (sk_cnt == 2'd2);
                    sk_cnt   <= sk_cnt - 2'd1;
                    rd_valid <= (sk_cnt == 2'd2);
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        rd_data <= ram_q;
                        rd_last <= inflight_last_q;
                    end else begin
                        rd_data  <= sk1_data;
                        rd_last  <= sk1_last;
                        sk1_data <= ram_q;
                        sk1_last <= inflight_last_q;
                    end
                    rd_valid <= 1'b1;
                end
                default: ;
            endcase

            unique case (state)
                CAPTURE: begin
                    if (any_wr && !in_range) begin
                        overflow <= 1'b1;
                    end
                    image_words <= words_next;
                    if (oio_rise) begin
                        rd_addr <= '0;
                        if (words_next == '0) begin
                            state         <= DONE;
                            readback_done <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (any_wr) begin
                        wr_while_busy <= 1'b1;
                    end
                    if (pop && rd_last) begin
                        state         <= DONE;
                        readback_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (any_wr) begin
                        wr_while_busy <= 1'b1;
                    end
                    if (!one_image_over) begin
                        state         <= CAPTURE;
                        image_words   <= '0;
                        overflow      <= 1'b0;
                        wr_while_busy <= 1'b0;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_codestream_readback.sv
// Randomized bench for codestream_readback against a queue-based image model.
module tb_codestream_readback;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk_dwt = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    write_en = '0;
    logic [31:0]   output_address = '0;
    logic [31:0]   output_to_fpga_32 = '0;
    logic          one_image_over = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          rd_last;
    logic [AW:0]   image_words;
    logic          overflow;
    logic          wr_while_busy;
    logic          readback_done;

    codestream_readback #(.ADDR_W(AW)) dut (
        .clk_dwt           (clk_dwt),
        .rst               (rst),
        .write_en          (write_en),
        .output_address    (output_address),
        .output_to_fpga_32 (output_to_fpga_32),
        .one_image_over    (one_image_over),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .rd_last           (rd_last),
        .image_words       (image_words),
        .overflow          (overflow),
        .wr_while_busy     (wr_while_busy),
        .readback_done     (readback_done)
    );

    always #5 clk_dwt = ~clk_dwt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic        last;
    } exp_t;

    typedef enum {M_CAP, M_DRAIN, M_DONE} mphase_t;

    logic [31:0] m_mem   [DEPTH];
    logic [31:0] m_known [DEPTH];
    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];
    mphase_t     m_phase = M_CAP;
    int          m_words = 0;
    bit          m_ovf = 0, m_busy = 0, m_done = 0, m_prev_oio = 0, armed = 0;
    int          age = 0;
    bit          hs_seen = 0, prev_stall = 0, prev_hs = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          done_cnt = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
    end

    always @(negedge clk_dwt) begin
        if (armed) begin
            chk("image_words", 32'(image_words), 32'(m_words));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wr_while_busy", 32'(wr_while_busy), 32'(m_busy));
            chk("readback_done", 32'(readback_done), 32'(m_done));
            if (readback_done) done_cnt++;
            if (m_phase == M_DRAIN && exp_q.size() > 0) begin
                age++;
                if (prev_stall) begin
                    chk("stall_valid", 32'(rd_valid), 32'd1);
                    chk("stall_data", rd_data, prev_data);
                    chk("stall_last", 32'(rd_last), 32'(prev_last));
                end
                if (prev_hs) chk("throughput_valid", 32'(rd_valid), 32'd1);
                if (age >= 3 && !hs_seen) chk("first_word_latency", 32'(rd_valid), 32'd1);
                if (rd_valid) begin
                    chk("rd_data", rd_data & exp_q[0].mask, exp_q[0].data & exp_q[0].mask);
                    chk("rd_last", 32'(rd_last), 32'(exp_q[0].last));
                end
            end else begin
                chk("idle_rd_valid", 32'(rd_valid), 32'd0);
            end
        end

        prev_stall = 0;
        prev_hs    = 0;
        m_done     = 0;
        if (rst) begin
            armed      = 1;
            m_phase    = M_CAP;
            m_words    = 0;
            m_ovf      = 0;
            m_busy     = 0;
            m_prev_oio = 0;
            exp_q.delete();
        end else if (armed) begin
            case (m_phase)
                M_CAP: begin
                    if (write_en != '0) begin
                        if (output_address < DEPTH) begin
                            for (int b = 0; b < 4; b++) begin
                                if (write_en[b]) begin
                                    m_mem[output_address[AW-1:0]][8*b +: 8]   = output_to_fpga_32[8*b +: 8];
                                    m_known[output_address[AW-1:0]][8*b +: 8] = 8'hFF;
                                end
                            end
                            if (int'(output_address) + 1 > m_words) m_words = int'(output_address) + 1;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    if (one_image_over && !m_prev_oio) begin
                        if (m_words == 0) begin
                            m_phase = M_DONE;
                            m_done  = 1;
                        end else begin
                            for (int i = 0; i < m_words; i++)
                                exp_q.push_back('{data: m_mem[i], mask: m_known[i], last: (i == m_words - 1)});
                            m_phase = M_DRAIN;
                            age     = 0;
                            hs_seen = 0;
                        end
                    end
                end
                M_DRAIN: begin
                    if (write_en != '0) m_busy = 1;
                    if (rd_valid && rd_ready) begin
                        got_q.push_back(rd_data);
                        got_last_q.push_back(rd_last);
                        hs_seen = 1;
                        prev_hs = 1;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_phase = M_DONE;
                            m_done  = 1;
                        end
                    end else if (rd_valid) begin
                        prev_stall = 1;
                        prev_data  = rd_data;
                        prev_last  = rd_last;
                    end
                end
                default: begin
                    if (write_en != '0) m_busy = 1;
                    if (!one_image_over) begin
                        m_phase = M_CAP;
                        m_words = 0;
                        m_ovf   = 0;
                        m_busy  = 0;
                    end
                end
            endcase
            m_prev_oio = one_image_over;
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ready  = 0;
    bit ready_level = 1;

    initial begin
        forever begin
            @(posedge clk_dwt);
            #1;
            rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    task automatic tick();
        @(posedge clk_dwt);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        output_address    = a;
        output_to_fpga_32 = d;
        write_en          = be;
        tick();
        write_en = '0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != start) break;
            tick();
        end
        chk(name, (done_cnt != start) ? 32'd1 : 32'd0, 32'd1);
        one_image_over = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_image(input string name, input int budget);
        one_image_over = 1'b1;
        wait_done(name, budget);
    endtask

    task automatic settle();
        @(negedge clk_dwt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;

        repeat (3) tick();
        rst = 1'b0;
        settle();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_image_words", 32'(image_words), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(wr_while_busy), 32'd0);
        chk("rst_done", 32'(readback_done), 32'd0);
        tick();

        // three full words, ready held high
        wr(32'd0, 32'hA1B2C3D4, 4'hF);
        wr(32'd1, 32'h11223344, 4'hF);
        wr(32'd2, 32'h55667788, 4'hF);
        settle();
        chk("s1_image_words", 32'(image_words), 32'd3);
        tick();
        base = got_q.size();
        run_image("s1_done", 50);
        chk("s1_count", 32'(got_q.size() - base), 32'd3);
        if (got_q.size() >= base + 3) begin
            chk("s1_w0", got_q[base], 32'hA1B2C3D4);
            chk("s1_w1", got_q[base+1], 32'h11223344);
            chk("s1_w2", got_q[base+2], 32'h55667788);
            chk("s1_last0", 32'(got_last_q[base]), 32'd0);
            chk("s1_last2", 32'(got_last_q[base+2]), 32'd1);
        end

        // partial byte-enable merge
        wr(32'd5, 32'hFFFFFFFF, 4'hF);
        wr(32'd5, 32'h00AA00BB, 4'b0101);
        settle();
        chk("s2_image_words", 32'(image_words), 32'd6);
        tick();
        base = got_q.size();
        run_image("s2_done", 50);
        chk("s2_count", 32'(got_q.size() - base), 32'd6);
        if (got_q.size() >= base + 6) chk("s2_w5", got_q[base+5], 32'hFFAAFFBB);

        // 8 words, random back-pressure
        for (int i = 0; i < 8; i++) wr(32'(i), $urandom, 4'hF);
        rand_ready = 1;
        base = got_q.size();
        run_image("s3_done", 300);
        chk("s3_count", 32'(got_q.size() - base), 32'd8);
        rand_ready = 0;

        // overflow, then write while draining
        wr(32'd1024, 32'hDEADBEEF, 4'hF);
        settle();
        chk("s4_overflow", 32'(overflow), 32'd1);
        chk("s4_words_unaffected", 32'(image_words), 32'd0);
        tick();
        wr(32'd0, 32'h12345678, 4'hF);
        wr(32'd1, 32'h9ABCDEF0, 4'hF);
        ready_level    = 0;
        one_image_over = 1'b1;
        repeat (3) tick();
        wr(32'd0, 32'hBAD0BAD0, 4'hF);
        settle();
        chk("s4_busy", 32'(wr_while_busy), 32'd1);
        tick();
        ready_level = 1;
        wait_done("s4_done", 50);
        wr(32'd1, 32'h0F0F0F0F, 4'hF);
        base = got_q.size();
        run_image("s4b_done", 50);
        chk("s4b_count", 32'(got_q.size() - base), 32'd2);
        if (got_q.size() >= base + 1) chk("s4b_w0_unchanged", got_q[base], 32'h12345678);

        // empty image
        base = got_q.size();
        run_image("s5_done", 20);
        chk("s5_no_words", 32'(got_q.size() - base), 32'd0);

        // reset partway through a drain
        for (int i = 0; i < 8; i++) wr(32'(i), $urandom, 4'hF);
        base = got_q.size();
        one_image_over = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (got_q.size() >= base + 2) break;
            tick();
        end
        chk("s6_two_drained", (got_q.size() >= base + 2) ? 32'd1 : 32'd0, 32'd1);
        rst            = 1'b1;
        one_image_over = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        chk("s6_rd_valid", 32'(rd_valid), 32'd0);
        chk("s6_rd_data", rd_data, 32'd0);
        chk("s6_rd_last", 32'(rd_last), 32'd0);
        chk("s6_image_words", 32'(image_words), 32'd0);
        chk("s6_done", 32'(readback_done), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) wr(32'(i), $urandom, 4'hF);
        base = got_q.size();
        run_image("s6b_done", 50);
        chk("s6b_count", 32'(got_q.size() - base), 32'd4);

        // random sparse images with random byte enables and back-pressure
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) wr(32'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            rand_ready = 1;
            run_image("rand_done", 300);
            rand_ready = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codestream_readback.md
CODESTREAM_READBACK -- requirements
Module: codestream_readback

Interface
REQ-001 Parameter ADDR_W, default 10, meaning log2 of buffer depth in 32-bit words.
REQ-002 clk_dwt  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 write_en  input  4  byte enables from tier-2 packer; bit i qualifies byte i (bits 8i+7:8i).
REQ-005 output_address  input  32  word address of current tier-2 write.
REQ-006 output_to_fpga_32  input  32  tier-2 codestream write data.
REQ-007 one_image_over  input  1  tier-2 end-of-image indication; level, sampled for rising edge.
REQ-008 rd_valid  output  1  readback word valid.
REQ-009 rd_ready  input  1  host accepts word when rd_valid and rd_ready are both high.
REQ-010 rd_data  output  32  readback word.
REQ-011 rd_last  output  1  high with final word of image.
REQ-012 image_words  output  ADDR_W+1  captured image length in words.
REQ-013 overflow  output  1  sticky; a write addressed at or beyond 2^ADDR_W words.
REQ-014 wr_while_busy  output  1  sticky; a write arrived outside CAPTURE.
REQ-015 readback_done  output  1  one-cycle pulse after final handshake.

Function
REQ-016 States: CAPTURE, DRAIN, DONE; reset enters CAPTURE.
REQ-017 CAPTURE, any write_en bit set: for each set bit, byte written into word output_address[ADDR_W-1:0]; clear bits leave bytes unchanged.
REQ-018 CAPTURE write with output_address >= 2^ADDR_W: no buffer write, overflow set.
REQ-019 CAPTURE: image_words = max(image_words, output_address+1) over in-range writes only, updated the cycle after the write.
REQ-020 Rising edge of one_image_over (registered previous value) in CAPTURE: go to DRAIN next cycle; a write in the same cycle is still captured and counted.
REQ-021 one_image_over rising with image_words = 0: go directly to DONE, no rd_valid, readback_done pulses.
REQ-022 DRAIN: words 0..image_words-1 presented in ascending order; buffer read latency one cycle; rd_valid first high at most 2 cycles after DRAIN entry.
REQ-023 rd_data/rd_valid/rd_last SHALL hold stable while rd_valid high and rd_ready low; no word dropped or duplicated under any rd_ready pattern.
REQ-024 Sustained throughput one word per cycle when rd_ready held high.
REQ-025 rd_last high exactly with word image_words-1.
REQ-026 After final handshake: readback_done pulses one cycle, state DONE, rd_valid low.
REQ-027 DONE: return to CAPTURE when one_image_over low; image_words, overflow, wr_while_busy cleared on that transition; buffer contents not cleared.
REQ-028 Writes in DRAIN or DONE: ignored, wr_while_busy set.
REQ-029 Never-written bytes within 0..image_words-1 read back as stale buffer contents (unspecified value).

Reset
REQ-030 rst high at clock edge: state CAPTURE, rd_valid 0, rd_data 0, rd_last 0, image_words 0, overflow 0, wr_while_busy 0, readback_done 0, edge register 0.
REQ-031 rst mid-DRAIN aborts readback immediately; no further rd_valid until next image.
REQ-032 Buffer contents not reset.

Structure
REQ-033 Shared package holds the state enumeration and default ADDR_W.
REQ-034 One sub-module, cs_buf_ram: simple dual-port 2^ADDR_W x 32, per-byte write enables, registered read, single clock clk_dwt.
REQ-035 Output side is a 2-entry skid buffer inside codestream_readback; no other sub-modules.

Verification
REQ-036 Writes 0xA1B2C3D4@0, 0x11223344@1, 0x55667788@2 (write_en=F), one_image_over rise, rd_ready=1 -> three words in order, rd_last on third, image_words=3, readback_done one cycle later.
REQ-037 Word 5 written 0xFFFFFFFF then write_en=0101 data 0x00AA00BB -> readback 0xFFAAFFBB, image_words=6.
REQ-038 8-word image, rd_ready toggled pseudo-randomly -> exactly 8 handshakes, stable data while stalled, no loss/duplicate.
REQ-039 ADDR_W=10, write at address 1024 -> overflow=1, image_words unaffected; write during DRAIN -> wr_while_busy=1, buffer unchanged.
REQ-040 one_image_over rise with no prior writes -> no rd_valid, readback_done pulses, DONE.
REQ-041 rst asserted after 2 of 8 words drained -> all outputs zero next cycle, state CAPTURE; subsequent 4-word image reads back correctly.
